// File: rtl/axi_burst_write_master.sv
`timescale 1ns/1ps
// AXI4 write-channel master: queues legal burst commands, issues AW with bounded
// outstanding bursts, streams user beats onto W with WLAST, and reports B responses.
module axi_burst_write_master #(
  parameter int AW              = 32,
  parameter int DW              = 64,
  parameter int IDW             = 4,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [IDW-1:0]                    cmd_id,
  input  logic [AW-1:0]                     cmd_addr,
  input  logic [7:0]                        cmd_len,
  input  logic [2:0]                        cmd_size,
  input  logic [1:0]                        cmd_burst,
  output logic                              cmd_err,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [DW-1:0]                     wr_data,
  input  logic [DW/8-1:0]                   wr_strb,
  output logic [IDW-1:0]                    m_axi_awid,
  output logic [AW-1:0]                     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DW-1:0]                     m_axi_wdata,
  output logic [DW/8-1:0]                   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [IDW-1:0]                    m_axi_bid,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic                              done_valid,
  output logic [IDW-1:0]                    done_id,
  output logic [1:0]                        done_resp,
  output logic                              done_err,
  output logic                              err_unexp_b,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              idle
);
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CPW   = $clog2(CMD_DEPTH);
  localparam int LPW   = $clog2(MAX_OUTSTANDING);
  localparam int MAXSZ = $clog2(DW / 8);

  typedef enum logic {AW_IDLE, AW_VALID} aw_state_t;
  typedef enum logic {W_IDLE, W_BURST}   w_state_t;

  function automatic logic cmd_legal(input logic [AW-1:0] a, input logic [7:0] l,
                                     input logic [2:0] s, input logic [1:0] b);
    logic [16:0] span;
    logic        ok;
    ok   = 1'b1;
    span = 17'(a[11:0]) + ((17'(l) + 17'd1) << s);
    if (b == 2'b11) ok = 1'b0;
    if (int'(s) > MAXSZ) ok = 1'b0;
    if (b == 2'b10) begin
      if (!(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) ok = 1'b0;
      if ((a & ((AW'(1) << s) - AW'(1))) != '0) ok = 1'b0;
    end
    if (b == 2'b01 && span > 17'd4096) ok = 1'b0;
    return ok;
  endfunction

  logic [IDW-1:0] cf_id    [CMD_DEPTH];
  logic [AW-1:0]  cf_addr  [CMD_DEPTH];
  logic [7:0]     cf_len   [CMD_DEPTH];
  logic [2:0]     cf_size  [CMD_DEPTH];
  logic [1:0]     cf_burst [CMD_DEPTH];
  logic [CPW:0]   cf_wr_q, cf_rd_q;
  logic [7:0]     wl_mem   [MAX_OUTSTANDING];
  logic [LPW:0]   wl_wr_q, wl_rd_q;

  aw_state_t      aw_state_q, aw_state_d;
  w_state_t       w_state_q, w_state_d;
  logic [7:0]     beat_q, beat_d;
  logic [OW-1:0]  out_q, out_d;
  logic [IDW-1:0] awid_q, done_id_q;
  logic [AW-1:0]  awaddr_q;
  logic [7:0]     awlen_q;
  logic [2:0]     awsize_q;
  logic [1:0]     awburst_q, done_resp_q;
  logic           cmd_err_q, done_valid_q, unexp_q;

  logic cf_empty, cf_full, wl_empty, wl_full;
  logic cmd_hs, cf_push, aw_pop, wl_pop, b_hs, b_ok, room;

  assign cf_empty = (cf_wr_q == cf_rd_q);
  assign cf_full  = (cf_wr_q[CPW] != cf_rd_q[CPW]) && (cf_wr_q[CPW-1:0] == cf_rd_q[CPW-1:0]);
  assign wl_empty = (wl_wr_q == wl_rd_q);
  assign wl_full  = (wl_wr_q[LPW] != wl_rd_q[LPW]) && (wl_wr_q[LPW-1:0] == wl_rd_q[LPW-1:0]);

  assign cmd_ready = !rst && !cf_full;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign cf_push   = cmd_hs && cmd_legal(cmd_addr, cmd_len, cmd_size, cmd_burst);

  assign m_axi_bready = !rst;
  assign b_hs = m_axi_bvalid && m_axi_bready;
  assign b_ok = b_hs && (out_q != '0);
  // A response retiring this cycle frees its slot for an issue in the same cycle
  assign room = (out_q < OW'(MAX_OUTSTANDING)) || b_ok;
  assign aw_pop = ((aw_state_q == AW_IDLE) || m_axi_awready) && !cf_empty && room && !wl_full;
  assign out_d  = out_q + OW'(aw_pop) - OW'(b_ok);

  always_comb begin
    aw_state_d = aw_state_q;
    case (aw_state_q)
      AW_IDLE:  if (aw_pop) aw_state_d = AW_VALID;
      AW_VALID: if (m_axi_awready) aw_state_d = aw_pop ? AW_VALID : AW_IDLE;
      default:  aw_state_d = AW_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    wl_pop    = 1'b0;
    case (w_state_q)
      W_IDLE: if (!wl_empty) begin
        wl_pop    = 1'b1;
        beat_d    = wl_mem[wl_rd_q[LPW-1:0]];
        w_state_d = W_BURST;
      end
      W_BURST: if (wr_valid && m_axi_wready) begin
        if (beat_q == 8'd0) w_state_d = W_IDLE;
        else                beat_d    = beat_q - 8'd1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // FIFO storage carries no reset; only the pointers define occupancy
  always_ff @(posedge clk) begin
    if (cf_push) begin
      cf_id[cf_wr_q[CPW-1:0]]    <= cmd_id;
      cf_addr[cf_wr_q[CPW-1:0]]  <= cmd_addr;
      cf_len[cf_wr_q[CPW-1:0]]   <= cmd_len;
      cf_size[cf_wr_q[CPW-1:0]]  <= cmd_size;
      cf_burst[cf_wr_q[CPW-1:0]] <= cmd_burst;
    end
    if (aw_pop) wl_mem[wl_wr_q[LPW-1:0]] <= cf_len[cf_rd_q[CPW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cf_wr_q      <= '0;
      cf_rd_q      <= '0;
      wl_wr_q      <= '0;
      wl_rd_q      <= '0;
      aw_state_q   <= AW_IDLE;
      w_state_q    <= W_IDLE;
      beat_q       <= '0;
      out_q        <= '0;
      awid_q       <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awsize_q     <= '0;
      awburst_q    <= '0;
      cmd_err_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_resp_q  <= '0;
      unexp_q      <= 1'b0;
    end else begin
      if (cf_push) cf_wr_q <= cf_wr_q + 1'b1;
      if (aw_pop) begin
        cf_rd_q   <= cf_rd_q + 1'b1;
        wl_wr_q   <= wl_wr_q + 1'b1;
        awid_q    <= cf_id[cf_rd_q[CPW-1:0]];
        awaddr_q  <= cf_addr[cf_rd_q[CPW-1:0]];
        awlen_q   <= cf_len[cf_rd_q[CPW-1:0]];
        awsize_q  <= cf_size[cf_rd_q[CPW-1:0]];
        awburst_q <= cf_burst[cf_rd_q[CPW-1:0]];
      end
      if (wl_pop) wl_rd_q <= wl_rd_q + 1'b1;
      aw_state_q   <= aw_state_d;
      w_state_q    <= w_state_d;
      beat_q       <= beat_d;
      out_q        <= out_d;
      cmd_err_q    <= cmd_hs && !cf_push;
      done_valid_q <= b_ok;
      if (b_ok) begin
        done_id_q   <= m_axi_bid;
        done_resp_q <= m_axi_bresp;
      end
      if (b_hs && out_q == '0) unexp_q <= 1'b1;
    end
  end

  assign m_axi_awid    = awid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = awburst_q;
  assign m_axi_awvalid = (aw_state_q == AW_VALID);
  assign m_axi_wvalid  = (w_state_q == W_BURST) && wr_valid;
  assign wr_ready      = (w_state_q == W_BURST) && m_axi_wready;
  assign m_axi_wlast   = (w_state_q == W_BURST) && (beat_q == 8'd0);
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign cmd_err       = cmd_err_q;
  assign done_valid    = done_valid_q;
  assign done_id       = done_id_q;
  assign done_resp     = done_resp_q;
  assign done_err      = done_resp_q[1];
  assign err_unexp_b   = unexp_q;
  assign outstanding   = out_q;
  assign idle          = cf_empty && (out_q == '0) && (w_state_q == W_IDLE);
endmodule

// File: tb/tb_axi_burst_write_master.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_burst_write_master: directed commands push expected AW,
// W and done entries; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_burst_write_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_err;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        done_valid, done_err, err_unexp_b, idle;
  logic [3:0]  done_id;
  logic [1:0]  done_resp;
  logic [2:0]  outstanding;

  axi_burst_write_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp), .done_err(done_err),
    .err_unexp_b(err_unexp_b), .outstanding(outstanding), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } aw_t;
  typedef struct { logic [63:0] data; logic last; } w_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } d_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  w_t  wsrc[$];
  d_t  exp_done[$];
  aw_t ea;
  w_t  ew, sw;
  d_t  ed;

  int nchk = 0;
  int nerr = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  bit w_fire = 1'b0;
  bit wtoggle = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: DUT event with empty expectation queue (got 1 required 0)", nm);
  endtask

  // Monitor: compare every AW/W handshake and done pulse against the scoreboard
  always @(negedge clk) begin
    w_fire = !rst && wr_valid && wr_ready;
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) unexp("aw_hs");
        else begin
          ea = exp_aw.pop_front();
          chk("awaddr", m_axi_awaddr, ea.addr);
          chk("awlen", m_axi_awlen, ea.len);
          chk("awid", m_axi_awid, ea.id);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_cnt++;
        if (exp_w.size() == 0) unexp("w_hs");
        else begin
          ew = exp_w.pop_front();
          chk("wdata", m_axi_wdata, ew.data);
          chk("wlast", m_axi_wlast, ew.last);
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) unexp("done");
        else begin
          ed = exp_done.pop_front();
          chk("done_id", done_id, ed.id);
          chk("done_resp", done_resp, ed.resp);
          chk("done_err", done_err, ed.resp[1]);
        end
      end
    end
  end

  // User beat source and W-ready generator
  always @(posedge clk) begin
    #1;
    if (w_fire && wsrc.size() > 0) void'(wsrc.pop_front());
    wr_valid = (wsrc.size() > 0);
    if (wsrc.size() > 0) begin
      sw = wsrc[0];
      wr_data = sw.data;
      wr_strb = 8'hFF;
    end
    m_axi_wready = wtoggle ? ~m_axi_wready : 1'b1;
  end

  task automatic nsamp();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit legal);
    int n;
    aw_t a;
    w_t  w;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
    cmd_size = size; cmd_burst = burst;
    n = 0;
    nsamp();
    while (!cmd_ready && n < 100) begin nsamp(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    if (legal) begin
      a.addr = addr; a.len = len; a.id = id;
      exp_aw.push_back(a);
      for (int b = 0; b <= int'(len); b++) begin
        w.data = 64'hA5A5_0000_0000_0000 + (64'(addr) << 8) + 64'(b);
        w.last = (b == int'(len));
        exp_w.push_back(w);
        wsrc.push_back(w);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    nsamp();
    chk("cmd_err", cmd_err, !legal);
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp, input bit expect_done);
    d_t d;
    @(posedge clk); #1;
    m_axi_bvalid = 1'b1; m_axi_bid = id; m_axi_bresp = resp;
    if (expect_done) begin d.id = id; d.resp = resp; exp_done.push_back(d); end
    @(posedge clk); #1;
    m_axi_bvalid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    do begin nsamp(); n++; end while ((exp_aw.size() > 0 || exp_w.size() > 0) && n < 300);
    chk(nm, (exp_aw.size() == 0 && exp_w.size() == 0), 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin nsamp(); n++; end while (!idle && n < 300);
    chk(nm, idle, 1'b1);
    chk({nm, "_done_q"}, exp_done.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout required finish)");
    $fatal(1);
  end

  int base, n;
  d_t dd;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_bvalid = 1'b0;
    repeat (3) @(posedge clk);
    nsamp();
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_unexp", err_unexp_b, 0);
    @(posedge clk); #1 rst = 1'b0;
    nsamp();
    chk("post_rst_bready", m_axi_bready, 1);
    chk("post_rst_idle", idle, 1);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Single-beat INCR
    send_cmd(4'd2, 32'h100, 8'd0, 3'd3, 2'b01, 1);
    wait_drain("t1_drain");
    send_b(4'd2, 2'b00, 1);
    wait_idle("t1_idle");
    chk("t1_outstanding", outstanding, 0);

    // 8-beat INCR, AW stalled, W ready toggling
    m_axi_awready = 1'b0;
    wtoggle = 1'b1;
    base = w_cnt;
    send_cmd(4'd5, 32'h200, 8'd7, 3'd3, 2'b01, 1);
    repeat (4) nsamp();
    chk("t2_aw_held_valid", m_axi_awvalid, 1);
    chk("t2_aw_held_addr", m_axi_awaddr, 32'h200);
    @(posedge clk); #1 m_axi_awready = 1'b1;
    wait_drain("t2_drain");
    chk("t2_wbeats", w_cnt - base, 8);
    wtoggle = 1'b0;
    send_b(4'd5, 2'b00, 1);
    wait_idle("t2_idle");

    // Illegal commands
    base = aw_cnt;
    send_cmd(4'd1, 32'h0, 8'd2, 3'd3, 2'b10, 0);
    send_cmd(4'd1, 32'hFF8, 8'd1, 3'd3, 2'b01, 0);
    send_cmd(4'd1, 32'h40, 8'd0, 3'd3, 2'b11, 0);
    repeat (4) nsamp();
    chk("t3_no_aw", aw_cnt - base, 0);
    chk("t3_outstanding", outstanding, 0);
    chk("t3_idle", idle, 1);

    // Outstanding limit with responses withheld
    base = aw_cnt;
    for (int i = 0; i < 6; i++)
      send_cmd(4'(i), 32'h1000 + 32'(i) * 32'h40, 8'd0, 3'd3, 2'b01, 1);
    repeat (10) nsamp();
    chk("t4_aw_count", aw_cnt - base, 4);
    chk("t4_outstanding", outstanding, 4);
    send_b(4'd0, 2'b00, 1);
    nsamp();
    chk("t4_aw5_next", m_axi_awvalid, 1);
    chk("t4_out_same", outstanding, 4);
    for (int i = 1; i < 6; i++) send_b(4'(i), 2'b00, 1);
    wait_drain("t4_drain");
    wait_idle("t4_idle");

    // SLVERR response in the same cycle as an AW issue
    m_axi_awready = 1'b0;
    send_cmd(4'd1, 32'h500, 8'd0, 3'd3, 2'b01, 1);
    send_cmd(4'd3, 32'h540, 8'd0, 3'd3, 2'b01, 1);
    repeat (2) nsamp();
    chk("t5_out_before", outstanding, 1);
    @(posedge clk); #1;
    m_axi_awready = 1'b1;
    m_axi_bvalid = 1'b1; m_axi_bid = 4'd1; m_axi_bresp = 2'b10;
    dd.id = 4'd1; dd.resp = 2'b10; exp_done.push_back(dd);
    @(posedge clk); #1 m_axi_bvalid = 1'b0;
    nsamp();
    chk("t5_out_same", outstanding, 1);
    chk("t5_aw_issued", m_axi_awvalid, 1);
    wait_drain("t5_drain");
    send_b(4'd3, 2'b00, 1);
    wait_idle("t5_idle");
    send_b(4'd9, 2'b00, 0);
    nsamp();
    chk("t5_unexp", err_unexp_b, 1);
    chk("t5_unexp_out", outstanding, 0);
    repeat (3) nsamp();
    chk("t5_unexp_sticky", err_unexp_b, 1);

    // Reset in the middle of an 8-beat burst
    base = w_cnt;
    send_cmd(4'd6, 32'h300, 8'd7, 3'd3, 2'b01, 1);
    n = 0;
    while (w_cnt - base < 3 && n < 200) begin nsamp(); n++; end
    chk("t6_three_beats", w_cnt - base, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_aw.delete(); exp_w.delete(); wsrc.delete(); exp_done.delete();
    @(posedge clk); #1 rst = 1'b0;
    nsamp();
    chk("t6_awvalid", m_axi_awvalid, 0);
    chk("t6_wvalid", m_axi_wvalid, 0);
    chk("t6_outstanding", outstanding, 0);
    chk("t6_idle", idle, 1);
    chk("t6_unexp_clr", err_unexp_b, 0);
    send_cmd(4'd7, 32'h400, 8'd1, 3'd3, 2'b01, 1);
    wait_drain("t6_drain");
    send_b(4'd7, 2'b00, 1);
    wait_idle("t6_idle_end");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
Parametrised AXI4 write-channel master engine: the next generation of the write-channel master/slave pairing, generalised in data/ID width and able to keep several bursts outstanding. Accepts burst commands on a valid/ready command port and streams write beats from a user data port. Drives AW/W/B with correct WLAST generation, checks command legality, bounds outstanding transactions, and reports each write response. Sits between user logic and the AXI interconnect in the write path.

Parameters:
AW, 32, address width
DW, 64, data width in bits (power of 2, 32..512); strobe width DW/8
IDW, 4, AXI ID width
CMD_DEPTH, 4, command FIFO entries (power of 2)
MAX_OUTSTANDING, 4, max issued-but-unresponded bursts (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command FIFO not full
cmd_id  in  IDW  burst ID
cmd_addr  in  AW  start address
cmd_len  in  8  beats minus 1
cmd_size  in  3  log2 bytes per beat
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
cmd_err  out  1  one-cycle pulse: illegal command dropped
wr_valid  in  1  user beat valid
wr_ready  out  1  user beat accepted
wr_data  in  DW  user beat data
wr_strb  in  DW/8  user beat strobes
m_axi_awid/awaddr/awlen/awsize/awburst  out  IDW/AW/8/3/2  AW payload
m_axi_awvalid  out  1 ; m_axi_awready  in  1
m_axi_wdata  out  DW ; m_axi_wstrb  out  DW/8 ; m_axi_wlast  out  1
m_axi_wvalid  out  1 ; m_axi_wready  in  1
m_axi_bid  in  IDW ; m_axi_bresp  in  2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1
done_valid  out  1  one-cycle pulse per completed burst
done_id  out  IDW ; done_resp  out  2 ; done_err  out  1 (= done_resp[1])
err_unexp_b  out  1  sticky: B received with outstanding count 0
outstanding  out  $clog2(MAX_OUTSTANDING)+1  issued-unresponded count
idle  out  1  cmd FIFO empty, outstanding 0, W FSM idle

Behaviour:
- Reset (sync, rst=1 at clk edge): all outputs 0 except m_axi_bready=0; FIFOs emptied, counters 0, FSMs idle, err_unexp_b cleared. Reset mid-burst abandons all in-flight state; no further beats or done pulses.
- Command legality checked at cmd handshake; illegal = burst 11; size > log2(DW/8); WRAP with len not in {1,3,7,15} or addr not size-aligned; INCR crossing 4 KB ((addr & 0xFFF) + ((len+1)<<size) > 4096). Illegal: cmd_err pulses next cycle, command not enqueued. cmd_ready = !cmd_fifo_full, independent of legality.
- AW FSM (AW_IDLE, AW_VALID): in AW_IDLE, if cmd FIFO non-empty and outstanding < MAX_OUTSTANDING, pop head, register AW payload, push len into W-length FIFO (depth MAX_OUTSTANDING), increment outstanding, go AW_VALID (awvalid=1 next cycle). In AW_VALID payload held stable until awready; on handshake return to AW_IDLE; back-to-back issue allowed (can pop in handshake cycle → no bubble).
- Outstanding: +1 on AW pop, -1 on B handshake; both same cycle → unchanged. Never exceeds MAX_OUTSTANDING; cmd acceptance continues into FIFO while stalled.
- W FSM (W_IDLE, W_BURST): W_IDLE loads beat counter from W-length FIFO head when non-empty (1 cycle), pops it, enters W_BURST. In W_BURST: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata/wstrb pass through combinationally, m_axi_wlast=(beat_cnt==0). Beat completes on wvalid&wready; counter decrements; last beat returns to W_IDLE. W beats may precede AW handshake. Outside W_BURST wvalid=0, wr_ready=0.
- B: m_axi_bready=1 whenever not in reset. B handshake with outstanding>0: next cycle done_valid=1, done_id=bid, done_resp=bresp. With outstanding==0: err_unexp_b set, no done pulse, counter unchanged. Responses reported in arrival order (out-of-order IDs allowed).
- FIFO full/empty: cmd FIFO full → cmd_ready=0; simultaneous push and pop when full not permitted (ready already low).

Test Plan:
- Single INCR cmd addr 0x100 len 0 size 3 id 2, wready=1, B OKAY → awaddr 0x100 awlen 0, one beat with wlast=1, done_valid with done_id=2 done_resp=0; idle returns 1.
- INCR len 7, wready toggling every other cycle → exactly 8 W handshakes, wlast only on 8th, wdata order preserved, awvalid held until awready.
- Illegal cmds: WRAP len 2; INCR addr 0xFF8 len 1 size 3; burst 11 → cmd_err pulse each, no AW issued, outstanding stays 0.
- 6 cmds, MAX_OUTSTANDING=4, B withheld → exactly 4 AW handshakes, outstanding=4; release one B → 5th AW issues next cycle.
- B with bresp=2 (SLVERR) same cycle as new AW pop → done_err=1, outstanding unchanged; B with outstanding 0 → err_unexp_b=1 sticky.
- rst asserted mid-burst after 3 of 8 beats → next cycle awvalid=wvalid=0, outstanding=0, idle=1; new command completes normally.
